// File: rtl/phase_marker_emitter.sv
// phase_marker_emitter
//   Merges a stream of phase commands into a pass-through instruction stream.
//   Each accepted command becomes a marker word (an ADDI-style encoding that
//   carries the phase id and START/END flag in its immediate). Commands have
//   priority over pass-through words. A SIM_EXIT command ends the run.
//
// Ports
//   clock, reset          : sole clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : phase command handshake
//   cmd_phase, cmd_end    : phase id (0..7) and START(0)/END(1)
//   in_valid/in_ready     : pass-through instruction input handshake
//   in_inst               : pass-through instruction word
//   out_valid/out_ready   : merged output handshake
//   out_inst              : merged output word
//   out_is_marker         : current output word is a marker
//   open_mask             : bit p set while phase p is open
//   err                   : sticky protocol error (double START / stray END)
//   done                  : SIM_EXIT marker consumed downstream
//   marker_count          : markers consumed downstream, saturating
module phase_marker_emitter #(
  parameter int CMD_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_phase,
  input  logic        cmd_end,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_is_marker,
  output logic [6:0]  open_mask,
  output logic        err,
  output logic        done,
  output logic [15:0] marker_count
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_EXITING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Marker word: imm = 2*phase + end for phases 0-6, 14 for SIM_EXIT.
  function automatic logic [31:0] f_encode(input logic [2:0] p, input logic e);
    logic [11:0] imm;
    if (p == 3'd7) begin
      imm = 12'd14;
    end else begin
      imm = {8'd0, p, e};
    end
    return {imm, 5'd0, 3'b010, 5'd0, 7'h13};
  endfunction

  state_t       r_state;
  logic [3:0]   r_fifo [CMD_DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         r_out_valid;
  logic [31:0]  r_out_inst;
  logic         r_out_is_marker;
  logic [6:0]   r_open_mask;
  logic         r_err;
  logic [15:0]  r_marker_count;

  logic         w_run;
  logic         w_fifo_empty;
  logic         w_fifo_full;
  logic         w_slot_free;
  logic         w_cmd_fire;
  logic         w_in_fire;
  logic         w_out_fire;
  logic         w_load_fifo;
  logic         w_load_bypass;
  logic         w_load_marker;
  logic         w_push;
  logic [3:0]   w_head;
  logic [2:0]   w_mk_phase;
  logic         w_mk_end;

  // Handshake, FIFO status and load-source selection.
  always_comb begin
    w_run        = (r_state == ST_RUN);
    w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    w_fifo_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_slot_free  = !r_out_valid || out_ready;
    cmd_ready    = w_run && !w_fifo_full;
    // An offered command wins the slot over a pass-through word.
    in_ready     = w_run && w_fifo_empty && w_slot_free && !cmd_valid;
    w_cmd_fire   = cmd_valid && cmd_ready;
    w_in_fire    = in_valid && in_ready;
    w_out_fire   = r_out_valid && out_ready;
    w_load_fifo  = w_run && w_slot_free && !w_fifo_empty;
    // With an empty FIFO the command skips the queue for 1-cycle latency.
    w_load_bypass = w_run && w_slot_free && w_fifo_empty && w_cmd_fire;
    w_load_marker = w_load_fifo || w_load_bypass;
    w_push       = w_cmd_fire && !w_load_bypass;
    w_head       = r_fifo[r_rd_ptr[AW-1:0]];
    if (w_load_fifo) begin
      w_mk_phase = w_head[3:1];
      w_mk_end   = w_head[0];
    end else begin
      w_mk_phase = cmd_phase;
      w_mk_end   = cmd_end;
    end
  end

  // Command FIFO storage; contents are don't-care while unused.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[AW-1:0]] <= {cmd_phase, cmd_end};
    end
  end

  // Control FSM, FIFO pointers, output slot and status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= ST_RUN;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_out_valid     <= 1'b0;
      r_out_inst      <= 32'd0;
      r_out_is_marker <= 1'b0;
      r_open_mask     <= 7'd0;
      r_err           <= 1'b0;
      r_marker_count  <= 16'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      // Once exiting, anything left in the queue is discarded.
      if (!w_run) begin
        r_rd_ptr <= r_wr_ptr;
      end else if (w_load_fifo) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_out_fire && r_out_is_marker && (r_marker_count != 16'hFFFF)) begin
        r_marker_count <= r_marker_count + 16'd1;
      end
      case (r_state)
        ST_RUN: begin
          if (w_load_marker) begin
            r_out_valid     <= 1'b1;
            r_out_inst      <= f_encode(w_mk_phase, w_mk_end);
            r_out_is_marker <= 1'b1;
            if (w_mk_phase == 3'd7) begin
              r_state <= ST_EXITING;
            end else begin
              if (w_mk_end != r_open_mask[w_mk_phase]) begin
                r_err <= 1'b1;
              end
              r_open_mask[w_mk_phase] <= !w_mk_end;
            end
          end else if (w_in_fire) begin
            r_out_valid     <= 1'b1;
            r_out_inst      <= in_inst;
            r_out_is_marker <= 1'b0;
          end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
          end
        end
        ST_EXITING: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_out_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign out_valid     = r_out_valid;
  assign out_inst      = r_out_inst;
  assign out_is_marker = r_out_is_marker;
  assign open_mask     = r_open_mask;
  assign err           = r_err;
  assign done          = (r_state == ST_DONE);
  assign marker_count  = r_marker_count;

endmodule

// File: tb/tb_phase_marker_emitter.sv
module tb_phase_marker_emitter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_phase = 3'd0;
  logic        cmd_end = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_is_marker;
  logic [6:0]  open_mask;
  logic        err;
  logic        done;
  logic [15:0] marker_count;

  phase_marker_emitter #(.CMD_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_phase(cmd_phase), .cmd_end(cmd_end),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_is_marker(out_is_marker), .open_mask(open_mask), .err(err),
    .done(done), .marker_count(marker_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] sb_q[$];
  logic [32:0] mon_exp;
  logic [32:0] held;
  logic        held_v = 1'b0;
  bit          exited = 1'b0;
  int          mk_seen = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference marker word: immediate lives in bits 31:20.
  function automatic logic [31:0] exp_marker(input int ph, input int e);
    int imm;
    imm = (ph == 7) ? 14 : 2 * ph + e;
    return (32'(imm) << 20) | 32'h0000_2013;
  endfunction

  // Scoreboard: consume on output handshake, produce on accepted input.
  always @(negedge clock) begin
    if (reset) begin
      sb_q.delete();
      exited  = 1'b0;
      mk_seen = 0;
      held_v  = 1'b0;
    end else begin
      if (held_v && out_valid) begin
        chk("hold_inst", out_inst, held[31:0]);
        chk("hold_marker", 32'(out_is_marker), 32'(held[32]));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          mon_exp = sb_q.pop_front();
          chk("out_inst", out_inst, mon_exp[31:0]);
          chk("out_is_marker", 32'(out_is_marker), 32'(mon_exp[32]));
          if (out_is_marker) mk_seen++;
        end
      end
      held_v = out_valid && !out_ready;
      held   = {out_is_marker, out_inst};
      if (cmd_valid && cmd_ready && !exited) begin
        sb_q.push_back({1'b1, exp_marker(int'(cmd_phase), int'(cmd_end))});
        if (cmd_phase == 3'd7) exited = 1'b1;
      end
      if (in_valid && in_ready && !exited) begin
        sb_q.push_back({1'b0, in_inst});
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_inst"}, out_inst, 32'd0);
    chk({tag, "_is_marker"}, 32'(out_is_marker), 32'd0);
    chk({tag, "_open_mask"}, 32'(open_mask), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_count"}, 32'(marker_count), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  int acc;
  bit took;
  int ph_tab[5] = '{6, 6, 1, 1, 3};
  int en_tab[5] = '{0, 1, 0, 1, 0};

  initial begin
    // Reset values and ready on first cycle.
    repeat (2) tick;
    reset = 1'b0;
    #1;
    chk_reset_state("rst");

    // TEXE START with free slot: marker one cycle later.
    tick;
    out_ready = 1'b1;
    cmd_valid = 1'b1; cmd_phase = 3'd2; cmd_end = 1'b0;
    tick;
    cmd_valid = 1'b0;
    #1;
    chk("texe_start_inst", out_inst, 32'h0040_2013);
    chk("texe_start_marker", 32'(out_is_marker), 32'd1);
    chk("texe_start_mask", 32'(open_mask), 32'h04);

    // Command and instruction offered together: marker first.
    tick;
    cmd_valid = 1'b1; cmd_phase = 3'd0; cmd_end = 1'b0;
    in_valid = 1'b1; in_inst = 32'h0000_0013;
    #1;
    chk("prio_in_ready", 32'(in_ready), 32'd0);
    tick;
    cmd_valid = 1'b0;
    #1;
    chk("prio_first", out_inst, 32'h0000_2013);
    tick;
    in_valid = 1'b0;
    #1;
    chk("prio_second", out_inst, 32'h0000_0013);
    chk("prio_second_flag", 32'(out_is_marker), 32'd0);
    chk("prio_mask", 32'(open_mask), 32'h05);

    // END of a closed phase raises sticky err.
    tick;
    cmd_valid = 1'b1; cmd_phase = 3'd5; cmd_end = 1'b1;
    tick;
    cmd_valid = 1'b0;
    #1;
    chk("bim_end_inst", out_inst, 32'h00b0_2013);
    chk("bim_end_err", 32'(err), 32'd1);

    // Random mix with back-pressure, then drain.
    for (int i = 0; i < 60; i++) begin
      tick;
      in_valid  = 1'($urandom_range(0, 1));
      in_inst   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_phase = 3'($urandom_range(0, 6));
      cmd_end   = 1'($urandom_range(0, 1));
    end
    tick;
    in_valid = 1'b0; cmd_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick;
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    chk("err_sticky", 32'(err), 32'd1);

    // Full FIFO: occupy stalled slot, offer 5 commands, 4 accepted.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hCAFE_0013;
    tick;
    in_valid = 1'b0;
    #1;
    chk("stall_word", out_inst, 32'hCAFE_0013);
    acc = 0;
    for (int c = 0; c < 7; c++) begin
      cmd_valid = 1'b1;
      cmd_phase = 3'(ph_tab[acc > 4 ? 4 : acc]);
      cmd_end   = 1'(en_tab[acc > 4 ? 4 : acc]);
      #1;
      took = cmd_ready;
      tick;
      if (took) acc++;
    end
    chk("full_accepted", 32'(acc), 32'd4);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("full_stable", out_inst, 32'hCAFE_0013);
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("burst_valid", 32'(out_valid), 32'd1);
      chk("burst_marker", 32'(out_is_marker), 32'd1);
    end
    tick;
    chk("burst_end", 32'(out_valid), 32'd0);

    // SIM_EXIT queued ahead of TRAIN START.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h1234_5013;
    tick;
    in_valid = 1'b0;
    cmd_valid = 1'b1; cmd_phase = 3'd7; cmd_end = 1'b0;
    tick;
    cmd_phase = 3'd6; cmd_end = 1'b0;
    tick;
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick;
    in_valid = 1'b1; cmd_valid = 1'b1;
    #1;
    chk("exit_done", 32'(done), 32'd1);
    chk("exit_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("exit_in_ready", 32'(in_ready), 32'd0);
    chk("exit_out_valid", 32'(out_valid), 32'd0);
    chk("exit_count", 32'(marker_count), 32'(mk_seen));
    tick;
    chk("exit_sb_empty", 32'(sb_q.size()), 32'd0);
    in_valid = 1'b0; cmd_valid = 1'b0;

    // Reset clears done/err; then saturate the marker counter.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk_reset_state("rst2");
    out_ready = 1'b1;
    cmd_valid = 1'b1; cmd_phase = 3'd0;
    for (int i = 0; i < 65540; i++) begin
      cmd_end = 1'(i % 2);
      tick;
      if (i == 1000) chk("count_mid", 32'(marker_count), 32'(mk_seen));
    end
    cmd_valid = 1'b0;
    repeat (3) tick;
    chk("count_sat", 32'(marker_count), 32'h0000_FFFF);
    chk("count_seen", 32'(mk_seen), 32'd65540);

    // Reset during a stall drops everything.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hDEAD_0013;
    tick;
    in_valid = 1'b0;
    cmd_valid = 1'b1; cmd_phase = 3'd3; cmd_end = 1'b0;
    tick;
    cmd_phase = 3'd4;
    tick;
    cmd_valid = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk_reset_state("rst3");
    out_ready = 1'b1;
    repeat (4) tick;
    chk("post_rst_idle", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/phase_marker_emitter.md
PHASE_MARKER_EMITTER -- requirements
Module: phase_marker_emitter

Interface
REQ-001 Parameter: CMD_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 clock  input  1  sole clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  phase command offered.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_phase  input  3  0 VCTM, 1 DELAY, 2 TEXE, 3 LEAK, 4 INIT, 5 BIM, 6 TRAIN, 7 SIM_EXIT.
REQ-007 cmd_end  input  1  0 START, 1 END; ignored for phase 7.
REQ-008 in_valid / in_ready / in_inst[31:0]  input / output / input  pass-through instruction stream.
REQ-009 out_valid / out_ready / out_inst[31:0]  output / input / output  merged instruction stream.
REQ-010 out_is_marker  output  1  current out word is a marker.
REQ-011 open_mask  output  7  bit p set while phase p is open.
REQ-012 err  output  1  sticky protocol error.
REQ-013 done  output  1  SIM_EXIT marker has been consumed downstream.
REQ-014 marker_count  output  16  markers consumed downstream, saturating.

Function
REQ-015 Marker encoding SHALL be {imm[11:0], 5'd0, 3'b010, 5'd0, 7'h13}, with imm = 2*phase + end for phases 0-6 and imm = 14 for phase 7 (e.g. TEXE END = 0x00502013, SIM_EXIT = 0x00e02013).
REQ-016 Commands SHALL be queued in a CMD_DEPTH FIFO; cmd_ready = (state==RUN) && !fifo_full.
REQ-017 The output SHALL be a single registered slot; the slot loads when (!out_valid || out_ready).
REQ-018 On load, a non-empty FIFO SHALL take priority: the head is popped, encoded into out_inst, and out_is_marker=1.
REQ-019 With an empty FIFO and in_valid, in_inst SHALL load unmodified with out_is_marker=0; in_ready = (state==RUN) && fifo_empty && (!out_valid || out_ready).
REQ-020 Pass-through latency SHALL be 1 cycle; cmd-to-out latency SHALL be 1 cycle when FIFO empty and slot free.
REQ-021 While out_valid && !out_ready, out_inst and out_is_marker SHALL hold stable.
REQ-022 Simultaneous enqueue and dequeue on a full FIFO SHALL NOT be accepted (cmd_ready already 0); on a non-full FIFO both SHALL occur in the same cycle.
REQ-023 On marker load, open_mask SHALL update: START sets bit, END clears bit.
REQ-024 START of an already-open phase or END of a closed phase SHALL set err; the marker is still emitted.
REQ-025 States: RUN, EXITING, DONE. RUN->EXITING when the SIM_EXIT marker loads; EXITING->DONE on its out handshake.
REQ-026 In EXITING and DONE, cmd_ready=0 and in_ready=0; remaining FIFO entries SHALL be discarded and never emitted.
REQ-027 done SHALL be 1 exactly in DONE.
REQ-028 marker_count SHALL increment on each out handshake with out_is_marker=1 and saturate at 0xFFFF.
REQ-029 FIFO pointers SHALL wrap modulo CMD_DEPTH with an extra bit distinguishing full from empty.

Reset
REQ-030 On reset: state RUN, FIFO empty, out_valid=0, out_inst=0, out_is_marker=0, open_mask=0, err=0, done=0, marker_count=0.
REQ-031 Reset mid-transfer SHALL drop the held out word and all queued commands, with no handshake on the next cycle.
REQ-032 After reset deasserts, cmd_ready=1 and in_ready=1 on the first cycle, provided cmd_valid=0.

Verification
REQ-033 Cmd phase 2 END=0 with out_ready=1 -> next cycle out_inst=0x00402013, out_is_marker=1, open_mask=0000100.
REQ-034 in_valid with in_inst=0x00000013 plus simultaneous cmd phase 0 START, FIFO empty -> marker 0x00002013 first, then 0x00000013 one cycle later; in_ready=0 in the marker cycle.
REQ-035 out_ready=0 while 5 commands are offered (CMD_DEPTH=4) -> 4 accepted, then cmd_ready=0; out_inst stable; after out_ready=1, markers emerge in order on consecutive cycles.
REQ-036 Cmd phase 5 END with open_mask=0 -> out_inst=0x00b02013, err=1, which stays 1 until reset.
REQ-037 SIM_EXIT queued ahead of TRAIN START -> 0x00e02013 emitted, TRAIN START never emitted, done=1 after handshake, cmd_ready=in_ready=0.
REQ-038 65540 marker handshakes -> marker_count=0xFFFF; reset mid-stall -> all outputs at REQ-030 values.
